// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold-until-release grants and a hold-time limit.
// Search starts at the priority pointer, which moves one past the owner whenever a grant ends.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout,
  output logic       state_dbg_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;

  // First set request bit at or after ptr, wrapping 7 -> 0.
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = BUSY;
          idx_d      = win_idx;
          grant_d    = 8'h01 << win_idx;
          hold_cnt_d = 8'd0;
        end
      end
      BUSY: begin
        // Release beats a dropped request, which beats the hold limit.
        if (release_i || !req[idx_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          grant_d   = 8'h00;
          ptr_d     = idx_q + 3'd1;
          timeout_d = !release_i && req[idx_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      grant_q    <= 8'h00;
      idx_q      <= 3'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == BUSY);
  assign timeout     = timeout_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD = 4): cycle scoreboard against a behavioural model,
// plus directed checks of the rotation, wrap, timeout, release/limit and reset scenarios.
module tb_rr_arbiter_8;

  localparam int MH = 4;

  // clock / reset
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       release_i = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic       state_dbg_o;

  always #5 sys_clk = ~sys_clk;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req        (req),
    .release_i  (release_i),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout),
    .state_dbg_o(state_dbg_o)
  );

  // scoreboard: {grant, grant_idx, grant_valid, timeout, busy}
  logic [13:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // behavioural model of the arbiter
  logic       m_busy = 1'b0;
  logic [2:0] m_ptr = 3'd0;
  int         m_hold = 0;
  logic [7:0] m_grant = 8'h00;
  logic [2:0] m_idx = 3'd0;
  logic       m_to = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [7:0] r, input logic rel);
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_hold = 0; m_grant = 0; m_idx = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (int'(m_ptr) + k) % 8;
        if (!m_busy && r[c]) begin
          m_busy = 1; m_idx = 3'(c); m_grant = 8'h01 << c; m_hold = 0;
        end
      end
    end else begin
      m_to = 0;
      if (rel || !r[m_idx] || m_hold == MH - 1) begin
        m_to    = !rel && r[m_idx];
        m_busy  = 0;
        m_grant = 0;
        m_ptr   = 3'((int'(m_idx) + 1) % 8);
      end else begin
        m_hold++;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, then compare the DUT against the popped expectation
  task automatic step(input logic rst, input logic [7:0] r, input logic rel);
    logic [13:0] exp_w, got_w;
    @(negedge sys_clk);
    sys_rst = rst; req = r; release_i = rel;
    model_step(rst, r, rel);
    exp_q.push_back({m_grant, m_idx, m_busy, m_to, m_busy});
    @(posedge sys_clk);
    #1;
    exp_w = exp_q.pop_front();
    got_w = {grant, grant_idx, grant_valid, timeout, state_dbg_o};
    check_eq("cycle", 16'(got_w), 16'(exp_w));
    check_eq("onehot", 16'($countones(grant) <= 1 && ((grant != 0) == grant_valid)), 16'd1);
  endtask

  initial begin
    // reset with all requests up
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hFF, 0);
      check_eq("rst_out", {3'b0, grant, grant_idx, grant_valid, timeout}, 16'd0);
    end
    step(0, 8'hFF, 0);
    check_eq("first_grant", 16'(grant), 16'h01);

    // rotation: release two cycles after each grant
    for (int k = 1; k <= 8; k++) begin
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);
      check_eq("rot_gap", 16'({grant, grant_valid}), 16'd0);
      step(0, 8'hFF, 0);
      check_eq("rot_grant", 16'(grant), 16'(8'h01 << (k % 8)));
      check_eq("rot_idx", 16'(grant_idx), 16'(k % 8));
    end
    step(0, 8'hFF, 1);

    // sparse requests with wrap; get ptr to 3 via a grant to idx 2
    step(0, 8'h04, 0);
    step(0, 8'h04, 1);
    step(0, 8'h84, 0);
    check_eq("sparse_hi", 16'(grant), 16'h80);
    step(0, 8'h84, 1);
    step(0, 8'h84, 0);
    check_eq("sparse_wrap", 16'(grant), 16'h04);
    step(0, 8'h84, 1);

    // timeout: exactly MH cycles of grant, then one-cycle timeout
    step(0, 8'h20, 0);
    check_eq("to_grant", 16'(grant), 16'h20);
    for (int i = 0; i < MH - 1; i++) begin
      step(0, 8'h20, 0);
      check_eq("to_held", 16'({grant_valid, timeout}), 16'b10);
    end
    step(0, 8'h20, 0);
    check_eq("to_pulse", 16'({grant_valid, timeout}), 16'b01);
    step(0, 8'h20, 0);
    check_eq("to_regrant", 16'({grant, timeout}), 16'h040);

    // release in the limit cycle: no timeout
    for (int i = 0; i < MH - 1; i++) step(0, 8'h20, 0);
    step(0, 8'h20, 1);
    check_eq("rel_vs_limit", 16'({grant_valid, timeout}), 16'b00);

    // owner drops its request mid-grant; ptr moves to 6
    step(0, 8'h20, 0);
    step(0, 8'h20, 0);
    step(0, 8'h00, 0);
    check_eq("drop_end", 16'({grant_valid, timeout}), 16'b00);
    step(0, 8'hFF, 0);
    check_eq("drop_ptr", 16'(grant), 16'h40);
    step(0, 8'hFF, 1);

    // reset in the middle of a grant to idx 5
    step(0, 8'h20, 0);
    check_eq("mid_idx", 16'(grant_idx), 16'd5);
    step(1, 8'hFF, 0);
    check_eq("mid_rst", {3'b0, grant, grant_idx, grant_valid, timeout}, 16'd0);
    step(0, 8'hFF, 0);
    check_eq("post_rst", 16'(grant), 16'h01);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
           $urandom_range(0, 5) == 0);
    end

    check_eq("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters. It encodes the winning requester as a 3-bit index and drives the matching one-hot grant line, using the same 3-to-8 decode relation as the team's decoder: grant[k] = 1 only when grant_idx = k. Grants are held until the owner releases, drops its request, or exceeds a hold-time limit. The block sits between the requesting modules and the shared resource's select logic.

## Interface
- MAX_HOLD, 16: maximum cycles a single grant may stay asserted; legal range 1–255.
- sys_clk  input  1  clock; all logic is on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[k] is high while requester k wants the resource.
- release  input  1  one-cycle pulse from the current owner to end its grant; ignored while no grant is valid.
- grant  output  8  one-hot grant; all zeros when grant_valid = 0.
- grant_idx  output  3  binary index of the current owner; holds its last value when grant_valid = 0.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is ended by the MAX_HOLD limit.

## Operation
- State machine with two states:
  - IDLE: no grant is active.
  - BUSY: one grant is active.
- Priority pointer ptr (3 bits) gives the first index searched.
  - Search order is ptr, ptr+1, …, ptr+7, modulo 8 (wraps 7 -> 0).
- In IDLE with req ≠ 0:
  - The winner is the first set bit of req in search order.
  - At the next edge: state = BUSY, grant_idx = winner, grant = 1 << winner, grant_valid = 1, hold_cnt = 0.
- In IDLE with req = 0: all outputs keep their values (grant = 0, grant_valid = 0).
- In BUSY, the grant ends at the next edge when any of these is true (checked in this order):
  1. release = 1.
  2. req[grant_idx] = 0.
  3. hold_cnt = MAX_HOLD−1. This case also sets timeout = 1 for exactly that one cycle.
- On end of grant:
  - state = IDLE, grant = 0, grant_valid = 0.
  - ptr = grant_idx + 1, mod 8, so 7 wraps to 0.
  - grant_idx keeps its value.
- Otherwise in BUSY, hold_cnt increments by 1. hold_cnt is 8 bits and never passes MAX_HOLD−1.
- If release and the limit occur in the same cycle, release wins and timeout stays 0.
- Requests from other requesters in BUSY have no effect; there is no preemption.
- Invariant: grant has popcount 0 or 1, and grant ≠ 0 exactly when grant_valid = 1.

## Timing
- Reset values:
  - grant = 8'h00, grant_idx = 3'd0, grant_valid = 0, timeout = 0.
  - ptr = 0, hold_cnt = 0, state = IDLE.
- Reset during BUSY: the grant drops at the edge where sys_rst is sampled high. No timeout pulse is generated.
- Request-to-grant latency: req sampled high at edge n in IDLE -> grant visible after edge n+1.
- Release-to-drop latency: release sampled at edge n -> grant = 0 after edge n+1.
- Turnaround: at least one IDLE cycle between two grants. After a release at edge n, the next grant appears after edge n+2 at the earliest.
- Grant length with no release and req held: exactly MAX_HOLD cycles of grant_valid = 1, then timeout high in the first cycle with grant_valid = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold sys_rst for 3 cycles with req = 8'hFF -> grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0 throughout. After releasing reset, the first grant is 8'h01 (ptr = 0).
- **Round-robin rotation:** req = 8'hFF, pulse release 2 cycles after each grant -> grant sequence is 01, 02, 04, 08, 10, 20, 40, 80, then wraps to 01. grant_idx runs 0..7, then 0. Each grant is followed by one cycle with grant = 0.
- **Sparse requests with wrap:** req = 8'b1000_0100 with ptr = 3 -> grant 8'h80 (idx 7). After it is released, ptr = 0 and the next grant is 8'h04 (idx 2).
- **Timeout:** MAX_HOLD = 4, req = 8'h20 held, no release -> grant_valid is high for exactly 4 cycles, then timeout pulses for 1 cycle. The next grant is 8'h20 again, appearing one cycle after the drop.
- **Simultaneous events:** MAX_HOLD = 4, release pulsed in the cycle where hold_cnt = 3 -> grant drops and timeout stays 0. Separately, drop req[owner] mid-grant -> the grant ends at the next edge and ptr advances.
- **Reset mid-grant:** during BUSY with idx = 5, assert sys_rst for 1 cycle -> all outputs return to reset values at that edge. The next grant with req = 8'hFF is 8'h01.
